exec_wb_buffer: RTL and testbench
=================================

# exec_wb_buffer

Result/writeback buffer sitting directly downstream of the execution units (logic, arithmetic, shift). It captures each completed result with its destination register index through a valid/ready handshake and holds it in a small in-order queue. It drains the queue into the register-file write port, which it shares with other writers via a grant signal. It also exposes a combinational forwarding lookup so decode/issue can bypass results that are not yet written.

## Interface
- W_OPR, 32, operand/result width; same value as the execution units.
- W_REG_ADDR, 5, register index width.
- DEPTH, 4, queue entries; power of two, at least 2.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  exec result valid
- in_ready_o  out  1  buffer can accept this cycle
- result_i  in  W_OPR  exec result
- dest_i  in  W_REG_ADDR  destination register
- rf_we_o  out  1  write request to register file
- rf_waddr_o  out  W_REG_ADDR  write address (head entry)
- rf_wdata_o  out  W_OPR  write data (head entry)
- rf_grant_i  in  1  write port granted this cycle
- query_addr_i  in  W_REG_ADDR  forwarding lookup address
- query_hit_o  out  1  a pending entry targets query_addr_i
- query_data_o  out  W_OPR  data of youngest matching entry
- count_o  out  log2(DEPTH)+1  occupied entries

## Operation
- Push: in_valid_i & in_ready_o at a rising edge stores {dest_i, result_i} at the tail.
- dest_i == 0: the handshake completes, but nothing is stored and count is unchanged. r0 is never written.
- in_ready_o = !rst & (count_o < DEPTH). It depends only on registered state and has no combinational path from rf_grant_i. Push on full is not accepted, even when a pop occurs in the same cycle.
- Pop: rf_we_o & rf_grant_i at a rising edge removes the head entry.
- Writes leave in strict FIFO order.
- Simultaneous push and pop: count unchanged; the head advances and the tail takes the new entry.
- rf_we_o = (count_o != 0).
- rf_waddr_o and rf_wdata_o show the head entry when non-empty and zero when empty.
- rf_grant_i low holds the head stable and does not change it.
- Forwarding:
  - query_hit_o is set if any valid entry has dest == query_addr_i.
  - query_data_o is the youngest such entry, so a later write wins.
  - query_addr_i == 0 never hits.
  - On a miss, query_data_o = 0.
  - The lookup sees registered state only; a same-cycle incoming push is not visible.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is determined from count_o, not from pointer equality.

## Timing
- Reset (rst high at an edge): count_o 0, pointers 0, rf_we_o 0, rf_waddr_o 0, rf_wdata_o 0, query_hit_o 0, query_data_o 0. in_ready_o is 0 while rst is high.
- Reset mid-operation: all pending entries are discarded, with no write for them. A push or grant in the reset cycle is ignored.
- Latency: a result pushed at edge N appears on rf_we_o/rf_waddr_o/rf_wdata_o and on the forwarding outputs after edge N (cycle N+1). The earliest write is at edge N+1 if granted.
- Throughput: 1 push and 1 pop per cycle sustained. With DEPTH entries and continuous grant, in_ready_o never drops.
- in_valid_i may deassert without a handshake, since the exec units are not required to hold. result_i/dest_i are sampled only on a handshake.

## Structure
- W_OPR and W_REG_ADDR come from the shared parameter include used by the exec units. The shared include also defines the entry width constant W_WB_ENTRY = W_OPR + W_REG_ADDR.
- Storage, pointers, and the forwarding comparator live in one module; there is no sub-module. The youngest-match search is a loop from head to tail in an always block. A generic FIFO would hide the entry array that forwarding needs, so a sub-module is not natural here.

## Test plan
- Reset then idle: after rst, count_o=0, rf_we_o=0, in_ready_o=1; query_addr_i=3 gives query_hit_o=0, query_data_o=0.
- Single write: push dest=5, result=0x0000_00FF with grant held low. Next cycle rf_we_o=1, waddr=5, wdata=0xFF, and query 5 hits 0xFF. Assert grant for 1 cycle and the buffer is empty the following cycle.
- Fill and backpressure (DEPTH=4): push 4 entries with grant low; in_ready_o=0 and a 5th push is not accepted. One grant gives in_ready_o=1 the next cycle, and the writes come out in push order.
- Forwarding priority: push dest=7 data 0x11, then dest=7 data 0x22; query 7 returns 0x22. After the first pop, still 0x22; after the second pop, a miss.
- r0 and wrap-around: push dest=0 and count stays 0. Run 10 push/pop pairs with grant held high; count stays ≤1 and all 10 writes are in order across the pointer wrap.
- Reset mid-operation: with 3 entries pending, pulse rst for 1 cycle. No further writes occur, count_o=0, and the first post-reset push is written correctly.

Source files
------------

// File: rtl/exec_wb_buffer_pkg.sv
// Shared execution-stage widths used by the exec units and the writeback buffer.
package exec_wb_buffer_pkg;

    localparam int unsigned W_OPR      = 32;
    localparam int unsigned W_REG_ADDR = 5;
    localparam int unsigned W_WB_ENTRY = W_OPR + W_REG_ADDR;

endpackage

// File: rtl/exec_wb_buffer.sv
// In-order result buffer between the exec units and the shared register-file write port,
// with a combinational youngest-match forwarding lookup over the pending entries.
module exec_wb_buffer
    import exec_wb_buffer_pkg::*;
#(
    parameter int unsigned W_OPR      = exec_wb_buffer_pkg::W_OPR,
    parameter int unsigned W_REG_ADDR = exec_wb_buffer_pkg::W_REG_ADDR,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [W_OPR-1:0]           result_i,
    input  logic [W_REG_ADDR-1:0]      dest_i,
    output logic                       rf_we_o,
    output logic [W_REG_ADDR-1:0]      rf_waddr_o,
    output logic [W_OPR-1:0]           rf_wdata_o,
    input  logic                       rf_grant_i,
    input  logic [W_REG_ADDR-1:0]      query_addr_i,
    output logic                       query_hit_o,
    output logic [W_OPR-1:0]           query_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W_REG_ADDR-1:0] r_dest [DEPTH];
    logic [W_OPR-1:0]      r_data [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [PW-1:0]         w_idx;

    assign w_empty    = (r_count == '0);
    // Readiness comes from the count alone, so a same-cycle pop never frees a full slot.
    assign in_ready_o = !rst && (r_count < CW'(DEPTH));
    assign w_push     = in_valid_i && in_ready_o && (dest_i != '0);
    assign w_pop      = !w_empty && rf_grant_i;

    assign rf_we_o    = !w_empty;
    assign rf_waddr_o = w_empty ? '0 : r_dest[r_head];
    assign rf_wdata_o = w_empty ? '0 : r_data[r_head];
    assign count_o    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_dest[r_tail] <= dest_i;
                r_data[r_tail] <= result_i;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        query_hit_o  = 1'b0;
        query_data_o = '0;
        w_idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (query_addr_i != '0) &&
                (r_dest[w_idx] == query_addr_i)) begin
                query_hit_o  = 1'b1;
                query_data_o = r_data[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_exec_wb_buffer.sv
// Self-checking bench for exec_wb_buffer: vector table, scoreboard on the write port,
// and directed sequences for backpressure, wrap-around and mid-operation reset.
module tb_exec_wb_buffer;

    localparam int unsigned W_OPR      = 32;
    localparam int unsigned W_REG_ADDR = 5;
    localparam int unsigned DEPTH      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [W_OPR-1:0]      result_i;
    logic [W_REG_ADDR-1:0] dest_i;
    logic                  rf_we_o;
    logic [W_REG_ADDR-1:0] rf_waddr_o;
    logic [W_OPR-1:0]      rf_wdata_o;
    logic                  rf_grant_i;
    logic [W_REG_ADDR-1:0] query_addr_i;
    logic                  query_hit_o;
    logic [W_OPR-1:0]      query_data_o;
    logic [2:0]            count_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [W_REG_ADDR+W_OPR-1:0] sb [$];

    typedef struct {
        logic                  v;
        logic [W_REG_ADDR-1:0] d;
        logic [W_OPR-1:0]      r;
        logic                  g;
        logic [W_REG_ADDR-1:0] q;
        logic [2:0]            c;
        logic                  we;
        logic [W_REG_ADDR-1:0] wa;
        logic [W_OPR-1:0]      wd;
        logic                  hit;
        logic [W_OPR-1:0]      qd;
    } vec_t;

    vec_t tbl [11];

    exec_wb_buffer #(
        .W_OPR      (W_OPR),
        .W_REG_ADDR (W_REG_ADDR),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .result_i     (result_i),
        .dest_i       (dest_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_grant_i   (rf_grant_i),
        .query_addr_i (query_addr_i),
        .query_hit_o  (query_hit_o),
        .query_data_o (query_data_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs for the next edge and record the expected write if it will handshake.
    task automatic drive(input logic v, input logic [W_REG_ADDR-1:0] d,
                         input logic [W_OPR-1:0] r, input logic g,
                         input logic [W_REG_ADDR-1:0] q);
        in_valid_i   = v;
        dest_i       = d;
        result_i     = r;
        rf_grant_i   = g;
        query_addr_i = q;
        #1;
        if (v && in_ready_o && !rst && d != '0) sb.push_back({d, r});
    endtask

    // Write-port scoreboard: every granted write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rf_we_o === 1'b1 && rf_grant_i === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected none",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                chk("write_order", {27'd0, rf_waddr_o}, {27'd0, sb[0][W_OPR+W_REG_ADDR-1:W_OPR]});
                chk("write_data", rf_wdata_o, sb[0][W_OPR-1:0]);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        //         v    d      r              g    q     c  we  wa     wd             hit  qd
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 3'd0, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b1, 5'd5, 32'h0000_00FF, 1'b0, 5'd5, 3'd1, 1'b1, 5'd5, 32'hFF, 1'b1, 32'hFF};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 3'd0, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 5'd7, 32'h11,       1'b0, 5'd7, 3'd1, 1'b1, 5'd7, 32'h11, 1'b1, 32'h11};
        tbl[4]  = '{1'b1, 5'd7, 32'h22,       1'b0, 5'd7, 3'd2, 1'b1, 5'd7, 32'h11, 1'b1, 32'h22};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 3'd1, 1'b1, 5'd7, 32'h22, 1'b1, 32'h22};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 3'd0, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0};
        tbl[7]  = '{1'b1, 5'd0, 32'h99,       1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0};
        tbl[8]  = '{1'b1, 5'd3, 32'hA,        1'b0, 5'd3, 3'd1, 1'b1, 5'd3, 32'hA,  1'b1, 32'hA};
        tbl[9]  = '{1'b1, 5'd4, 32'hB,        1'b1, 5'd3, 3'd1, 1'b1, 5'd4, 32'hB,  1'b0, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 3'd0, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0};

        chk("reset_count", {29'd0, count_o}, 32'd0);
        chk("reset_we", {31'd0, rf_we_o}, 32'd0);
        chk("reset_ready", {31'd0, in_ready_o}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].g, tbl[i].q);
            tick();
            chk($sformatf("v%0d_count", i), {29'd0, count_o}, {29'd0, tbl[i].c});
            chk($sformatf("v%0d_we", i), {31'd0, rf_we_o}, {31'd0, tbl[i].we});
            chk($sformatf("v%0d_waddr", i), {27'd0, rf_waddr_o}, {27'd0, tbl[i].wa});
            chk($sformatf("v%0d_wdata", i), rf_wdata_o, tbl[i].wd);
            chk($sformatf("v%0d_hit", i), {31'd0, query_hit_o}, {31'd0, tbl[i].hit});
            chk($sformatf("v%0d_qdata", i), query_data_o, tbl[i].qd);
        end

        // Fill with grant low, then a refused push while full, then a pop with push held.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), $urandom, 1'b0, '0);
            tick();
        end
        chk("full_count", {29'd0, count_o}, 32'd4);
        chk("full_ready", {31'd0, in_ready_o}, 32'd0);
        drive(1'b1, 5'd20, 32'hDEAD, 1'b0, 5'd20);
        tick();
        chk("full_refused_count", {29'd0, count_o}, 32'd4);
        chk("full_refused_hit", {31'd0, query_hit_o}, 32'd0);
        drive(1'b1, 5'd21, 32'hBEEF, 1'b1, '0);
        tick();
        chk("pop_on_full_count", {29'd0, count_o}, 32'd3);
        chk("pop_on_full_ready", {31'd0, in_ready_o}, 32'd1);
        drive(1'b0, '0, '0, 1'b1, '0);
        for (int n = 0; n < 20 && count_o != 0; n++) tick();
        chk("drain_count", {29'd0, count_o}, 32'd0);

        // Streaming push/pop across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(1 + i), 32'h100 + i, 1'b1, '0);
            tick();
            chk("wrap_count_le1", {31'd0, count_o <= 3'd1}, 32'd1);
            chk("wrap_ready", {31'd0, in_ready_o}, 32'd1);
        end
        drive(1'b0, '0, '0, 1'b1, '0);
        for (int n = 0; n < 20 && count_o != 0; n++) tick();
        chk("wrap_drain", {29'd0, count_o}, 32'd0);
        chk("wrap_sb_empty", sb.size(), 32'd0);

        // Reset with entries pending; push and grant during the reset cycle are ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(25 + i), $urandom, 1'b0, '0);
            tick();
        end
        chk("pre_reset_count", {29'd0, count_o}, 32'd3);
        rst = 1'b1;
        drive(1'b1, 5'd30, 32'h5555, 1'b1, 5'd25);
        chk("ready_in_reset", {31'd0, in_ready_o}, 32'd0);
        tick();
        rst = 1'b0;
        sb.delete();
        drive(1'b0, '0, '0, 1'b1, 5'd25);
        chk("post_reset_count", {29'd0, count_o}, 32'd0);
        chk("post_reset_hit", {31'd0, query_hit_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_no_write", {31'd0, rf_we_o}, 32'd0);
        end
        drive(1'b1, 5'd9, 32'h1234_5678, 1'b0, 5'd9);
        tick();
        chk("post_reset_push_hit", query_data_o, 32'h1234_5678);
        drive(1'b0, '0, '0, 1'b1, '0);
        tick();
        chk("post_reset_final_count", {29'd0, count_o}, 32'd0);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
